// File: rtl/if_inst_queue.sv
// Instruction queue between IF and ID: first-word-fall-through circular buffer
// of {adel, pc, inst} entries with valid/ready on both sides and a flush.
module if_inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  input  logic [31:0]                push_pc_i,
  input  logic [31:0]                push_inst_i,
  input  logic                       push_adel_i,
  output logic                       push_ready_o,
  output logic                       pop_valid_o,
  output logic [31:0]                pop_pc_o,
  output logic [31:0]                pop_inst_o,
  output logic                       pop_adel_o,
  input  logic                       pop_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [64:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           do_push;
  logic           do_pop;
  logic [64:0]    head;

  // Occupancy counter is the only source of full/empty.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push_valid_i && !full;
  assign do_pop  = !empty && pop_ready_i;

  // Pointer and occupancy state; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush_i) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage; deliberately not reset, stale data is masked by empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr] <= {push_adel_i, push_pc_i, push_inst_i};
    end
  end

  // Head presentation, forced to zero when the queue is empty.
  always_comb begin
    head = 65'd0;
    if (!empty) begin
      head = mem[rd_ptr];
    end else begin
      head = 65'd0;
    end
  end

  assign pop_valid_o  = !empty;
  assign pop_adel_o   = head[64];
  assign pop_pc_o     = head[63:32];
  assign pop_inst_o   = head[31:0];
  assign push_ready_o = !full;
  assign count_o      = count;

endmodule
